// File: rtl/rx_pkg.sv
// Shared defaults and helpers for the receive demux/deserialiser slice.
package rx_pkg;

  localparam int RX_IN_W  = 16;
  localparam int RX_RATIO = 2;
  localparam int RX_NCH   = 2;
  localparam int RX_CNT_W = 16;

  // Width of a counter that indexes 0..ratio-1; never less than one bit.
  function automatic int rx_phase_w(input int ratio);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < ratio) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rx_lane_pack.sv
// One channel's sample slots and packed-word assembly. The final sample
// of a group is not stored; it is merged straight from the capture
// register so the word is ready on the completing edge.
module rx_lane_pack
  import rx_pkg::*;
#(
  parameter int IN_W      = RX_IN_W,
  parameter int RATIO     = RX_RATIO,
  parameter int FIRST_LOW = 1,
  parameter int PH_W      = rx_phase_w(RX_RATIO)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr,
  input  logic [PH_W-1:0]       i_idx,
  input  logic [IN_W-1:0]       i_dat,
  output logic [IN_W*RATIO-1:0] o_word
);

  logic [IN_W-1:0] r_slot [RATIO-1];

  // Store each non-final sample of a group into the slot picked by its phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the slots are plain flops rather than a RAM, so they take the
      // reset and Out_data never exposes stale samples after reset.
      for (int j = 0; j < RATIO - 1; j++) r_slot[j] <= '0;
    end else begin
      for (int j = 0; j < RATIO - 1; j++) begin
        // NOTE: state is updated with non-blocking assignments so every
        // flop samples the pre-edge value of every other flop.
        if (i_wr && (i_idx == PH_W'(j))) r_slot[j] <= i_dat;
      end
    end
  end

  // Assemble the word: earliest sample at the low or high end of the word.
  always_comb begin
    // NOTE: a full default before any conditional write keeps this block
    // free of inferred latches.
    o_word = '0;
    for (int j = 0; j < RATIO - 1; j++) begin
      if (FIRST_LOW != 0) o_word[j*IN_W +: IN_W] = r_slot[j];
      else                o_word[(RATIO-1-j)*IN_W +: IN_W] = r_slot[j];
    end
    if (FIRST_LOW != 0) o_word[(RATIO-1)*IN_W +: IN_W] = i_dat;
    else                o_word[IN_W-1:0] = i_dat;
  end

endmodule

// File: rtl/rx_demux_deser.sv
// Multi-channel receive demultiplexer/deserialiser. Registers the receiver
// bus, packs RATIO samples per channel into one word in lockstep across
// channels, and presents words on a valid/ready port with sticky overflow
// and a saturating dropped-word counter.
module rx_demux_deser
  import rx_pkg::*;
#(
  parameter int IN_W      = RX_IN_W,
  parameter int RATIO     = RX_RATIO,
  parameter int NCH       = RX_NCH,
  parameter int FIRST_LOW = 1,
  parameter int CNT_W     = RX_CNT_W
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic [NCH*IN_W-1:0]         In_dat,
  input  logic                        In_en,
  input  logic                        In_sync,
  output logic [NCH*RATIO*IN_W-1:0]   Out_data,
  output logic                        Out_valid,
  input  logic                        Out_ready,
  output logic                        Overflow,
  output logic [CNT_W-1:0]            Ovf_count,
  input  logic                        Ovf_clr
);

  localparam int              OUT_W   = IN_W * RATIO;
  localparam int              PH_W    = rx_phase_w(RATIO);
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(RATIO - 1);

  // Capture stage
  logic [NCH*IN_W-1:0] r_cap_dat;
  logic                r_cap_en;
  logic                r_cap_sync;

  // Pack stage
  logic [PH_W-1:0]     r_phase;
  logic [PH_W-1:0]     w_phase_eff;
  logic                w_complete;
  logic                w_slot_wr;
  logic [NCH*OUT_W-1:0] w_word;

  // Output and accounting
  logic [NCH*OUT_W-1:0] r_out_data;
  logic                 r_out_valid;
  logic                 r_overflow;
  logic [CNT_W-1:0]     r_ovf_count;
  logic                 w_load;
  logic                 w_drop;

  // Register the receiver bus so the packing logic sees only flopped inputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cap_dat  <= '0;
      r_cap_en   <= 1'b0;
      r_cap_sync <= 1'b0;
    end else begin
      r_cap_dat  <= In_dat;
      r_cap_en   <= In_en;
      r_cap_sync <= In_sync & In_en;
    end
  end

  // A qualified sync forces phase 0 and silently abandons any partial group.
  assign w_phase_eff = r_cap_sync ? '0 : r_phase;
  assign w_complete  = r_cap_en && (w_phase_eff == LAST_PH);
  assign w_slot_wr   = r_cap_en && (w_phase_eff != LAST_PH);

  // Advance the shared phase only on enabled samples; gaps hold the group.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_phase <= '0;
    end else if (r_cap_en) begin
      if (w_complete) r_phase <= '0;
      else            r_phase <= w_phase_eff + PH_W'(1);
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    rx_lane_pack #(
      .IN_W      (IN_W),
      .RATIO     (RATIO),
      .FIRST_LOW (FIRST_LOW),
      .PH_W      (PH_W)
    ) u_lane (
      .clk    (Clk),
      .rst_n  (Reset_n),
      .i_wr   (w_slot_wr),
      .i_idx  (w_phase_eff),
      .i_dat  (r_cap_dat[c*IN_W +: IN_W]),
      .o_word (w_word[c*OUT_W +: OUT_W])
    );
  end

  // A finished word loads when the output is empty or being consumed now;
  // otherwise it is dropped and the held word stays intact.
  assign w_load = w_complete && (!r_out_valid || Out_ready);
  assign w_drop = w_complete &&  r_out_valid && !Out_ready;

  // Output word register: changes only on a load.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_out_data <= '0;
    end else if (w_load) begin
      r_out_data <= w_word;
    end
  end

  // Valid flag: set on load, cleared when consumed with nothing new arriving.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
    end else if (r_out_valid && Out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky overflow flag; clear wins over a drop on the same edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_overflow <= 1'b0;
    end else if (Ovf_clr) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  // Saturating dropped-word counter; clear wins over an increment.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_ovf_count <= '0;
    end else if (Ovf_clr) begin
      r_ovf_count <= '0;
    end else if (w_drop && (r_ovf_count != '1)) begin
      r_ovf_count <= r_ovf_count + CNT_W'(1);
    end
  end

  assign Out_data  = r_out_data;
  assign Out_valid = r_out_valid;
  assign Overflow  = r_overflow;
  assign Ovf_count = r_ovf_count;

endmodule

// File: tb/tb_rx_demux_deser.sv
// Bench for rx_demux_deser: a default instance (16-bit, ratio 2, two
// channels) and a narrow instance (8-bit, ratio 4, one channel, earliest
// sample in the MSBs, 2-bit counter). Expected words go into a queue when
// the last sample of a group is driven, tagged with the edge at which they
// must appear, and are popped when the DUT presents a fresh word.
module tb_rx_demux_deser;

  typedef struct {
    logic [63:0] word;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          edge_cnt = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  // Instance A: defaults
  logic [31:0] a_dat = '0;
  logic        a_en = 1'b0, a_sync = 1'b0, a_ready = 1'b1, a_clr = 1'b0;
  logic [63:0] a_data;
  logic        a_valid, a_ovf;
  logic [15:0] a_cnt;
  logic        a_prev_valid = 1'b0;
  exp_t        qa[$];

  // Instance B: IN_W=8, RATIO=4, NCH=1, FIRST_LOW=0, CNT_W=2
  logic [7:0]  b_dat = '0;
  logic        b_en = 1'b0, b_sync = 1'b0, b_ready = 1'b1, b_clr = 1'b0;
  logic [31:0] b_data;
  logic        b_valid, b_ovf;
  logic [1:0]  b_cnt;
  logic        b_prev_valid = 1'b0;
  exp_t        qb[$];

  rx_demux_deser dut_a (
    .Clk(clk), .Reset_n(rst_n), .In_dat(a_dat), .In_en(a_en), .In_sync(a_sync),
    .Out_data(a_data), .Out_valid(a_valid), .Out_ready(a_ready),
    .Overflow(a_ovf), .Ovf_count(a_cnt), .Ovf_clr(a_clr)
  );

  rx_demux_deser #(.IN_W(8), .RATIO(4), .NCH(1), .FIRST_LOW(0), .CNT_W(2)) dut_b (
    .Clk(clk), .Reset_n(rst_n), .In_dat(b_dat), .In_en(b_en), .In_sync(b_sync),
    .Out_data(b_data), .Out_valid(b_valid), .Out_ready(b_ready),
    .Overflow(b_ovf), .Ovf_count(b_cnt), .Ovf_clr(b_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // A word is fresh if valid is up and the previous one was absent or consumed.
  task automatic mon_a();
    exp_t e;
    if (a_valid && (!a_prev_valid || a_ready)) begin
      n_cmp++;
      if (qa.size() == 0) begin
        n_err++;
        $display("FAIL a_unexpected_word: got %h at edge %0d, expected no word", a_data, edge_cnt);
      end else begin
        e = qa.pop_front();
        if (a_data !== e.word || edge_cnt != e.due) begin
          n_err++;
          $display("FAIL a_word: got %h at edge %0d, expected %h at edge %0d", a_data, edge_cnt, e.word, e.due);
        end
      end
    end
    a_prev_valid = a_valid;
  endtask

  task automatic mon_b();
    exp_t e;
    if (b_valid && (!b_prev_valid || b_ready)) begin
      n_cmp++;
      if (qb.size() == 0) begin
        n_err++;
        $display("FAIL b_unexpected_word: got %h at edge %0d, expected no word", b_data, edge_cnt);
      end else begin
        e = qb.pop_front();
        if (b_data !== e.word[31:0] || edge_cnt != e.due) begin
          n_err++;
          $display("FAIL b_word: got %h at edge %0d, expected %h at edge %0d", b_data, edge_cnt, e.word[31:0], e.due);
        end
      end
    end
    b_prev_valid = b_valid;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mon_a();
    mon_b();
  endtask

  task automatic cycle_a(input logic [15:0] d0, input logic [15:0] d1, input logic en,
                         input logic sync, input bit push, input logic [63:0] exp_w);
    exp_t e;
    a_dat = {d1, d0}; a_en = en; a_sync = sync;
    if (push) begin
      e.word = exp_w; e.due = edge_cnt + 2;
      qa.push_back(e);
    end
    tick();
  endtask

  task automatic cycle_b(input logic [7:0] d, input logic en, input logic sync,
                         input bit push, input logic [31:0] exp_w);
    exp_t e;
    b_dat = d; b_en = en; b_sync = sync;
    if (push) begin
      e.word = {32'h0, exp_w}; e.due = edge_cnt + 2;
      qb.push_back(e);
    end
    tick();
  endtask

  task automatic idle(input int n);
    a_en = 1'b0; a_sync = 1'b0; b_en = 1'b0; b_sync = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_drained(input string name);
    n_cmp++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_err++;
      $display("FAIL %s_drained: got %0d/%0d words outstanding, expected 0/0", name, qa.size(), qb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (a_valid !== 1'b0 || a_data !== 64'h0 || a_ovf !== 1'b0 || a_cnt !== 16'h0) begin
      n_err++;
      $display("FAIL reset_a: got v=%b d=%h o=%b c=%h, expected all zero", a_valid, a_data, a_ovf, a_cnt);
    end
    n_cmp++;
    if (b_valid !== 1'b0 || b_data !== 32'h0 || b_ovf !== 1'b0 || b_cnt !== 2'h0) begin
      n_err++;
      $display("FAIL reset_b: got v=%b d=%h o=%b c=%h, expected all zero", b_valid, b_data, b_ovf, b_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    a_prev_valid = 1'b0; b_prev_valid = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    a_ready = 1'b1;
    cycle_a(16'h0001, 16'h1001, 1, 1, 0, '0);
    cycle_a(16'h0002, 16'h1002, 1, 0, 1, 64'h10021001_00020001);
    cycle_a(16'h0003, 16'h1003, 1, 0, 0, '0);
    cycle_a(16'h0004, 16'h1004, 1, 0, 1, 64'h10041003_00040003);
    idle(3);
    expect_drained("basic");
  endtask

  task automatic test_back_to_back();
    logic [15:0] s0, s1, t0, t1;
    a_ready = 1'b1;
    for (int w = 0; w < 6; w++) begin
      s0 = 16'($urandom); t0 = 16'($urandom);
      s1 = 16'($urandom); t1 = 16'($urandom);
      cycle_a(s0, t0, 1, 0, 0, '0);
      cycle_a(s1, t1, 1, 0, 1, {t1, t0, s1, s0});
    end
    idle(3);
    expect_drained("back_to_back");
    n_cmp++;
    if (a_ovf !== 1'b0 || a_cnt !== 16'h0) begin
      n_err++;
      $display("FAIL back_to_back_ovf: got o=%b c=%0d, expected 0/0", a_ovf, a_cnt);
    end
  endtask

  task automatic test_gaps();
    a_ready = 1'b1;
    cycle_a(16'hAAAA, 16'hCCCC, 1, 0, 0, '0);
    cycle_a(16'hFFFF, 16'hFFFF, 0, 0, 0, '0);
    cycle_a(16'hEEEE, 16'hEEEE, 0, 1, 0, '0);
    cycle_a(16'hBBBB, 16'hDDDD, 1, 0, 1, 64'hDDDDCCCC_BBBBAAAA);
    idle(3);
    expect_drained("gaps");
  endtask

  task automatic test_sync_mid();
    a_ready = 1'b1;
    cycle_a(16'h0005, 16'h1005, 1, 1, 0, '0);
    cycle_a(16'h0006, 16'h1006, 1, 1, 0, '0);
    cycle_a(16'h0007, 16'h1007, 1, 0, 1, 64'h10071006_00070006);
    idle(3);
    expect_drained("sync_mid");
    n_cmp++;
    if (a_ovf !== 1'b0 || a_cnt !== 16'h0) begin
      n_err++;
      $display("FAIL sync_mid_ovf: got o=%b c=%0d, expected 0/0", a_ovf, a_cnt);
    end
  endtask

  task automatic test_overflow();
    a_ready = 1'b0;
    cycle_a(16'h0021, 16'h1021, 1, 0, 0, '0);
    cycle_a(16'h0022, 16'h1022, 1, 0, 1, 64'h10221021_00220021);
    cycle_a(16'h0023, 16'h1023, 1, 0, 0, '0);
    cycle_a(16'h0024, 16'h1024, 1, 0, 0, '0);
    cycle_a(16'h0025, 16'h1025, 1, 0, 0, '0);
    cycle_a(16'h0026, 16'h1026, 1, 0, 0, '0);
    idle(2);
    n_cmp++;
    if (a_valid !== 1'b1 || a_data !== 64'h10221021_00220021) begin
      n_err++;
      $display("FAIL ovf_hold: got v=%b d=%h, expected v=1 d=1022102100220021", a_valid, a_data);
    end
    n_cmp++;
    if (a_ovf !== 1'b1 || a_cnt !== 16'd2) begin
      n_err++;
      $display("FAIL ovf_count: got o=%b c=%0d, expected o=1 c=2", a_ovf, a_cnt);
    end
    a_ready = 1'b1;
    idle(1);
    n_cmp++;
    if (a_valid !== 1'b0 || a_data !== 64'h10221021_00220021) begin
      n_err++;
      $display("FAIL ovf_consume: got v=%b d=%h, expected v=0 d unchanged", a_valid, a_data);
    end
    a_clr = 1'b1;
    idle(1);
    a_clr = 1'b0;
    n_cmp++;
    if (a_ovf !== 1'b0 || a_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL ovf_clear: got o=%b c=%0d, expected 0/0", a_ovf, a_cnt);
    end
    // A drop coinciding with the clear edge is not counted.
    a_ready = 1'b0;
    cycle_a(16'h0041, 16'h1041, 1, 0, 0, '0);
    cycle_a(16'h0042, 16'h1042, 1, 0, 1, 64'h10421041_00420041);
    cycle_a(16'h0043, 16'h1043, 1, 0, 0, '0);
    cycle_a(16'h0044, 16'h1044, 1, 0, 0, '0);
    a_clr = 1'b1;
    idle(1);
    a_clr = 1'b0;
    n_cmp++;
    if (a_ovf !== 1'b0 || a_cnt !== 16'd0 || a_data !== 64'h10421041_00420041) begin
      n_err++;
      $display("FAIL ovf_clr_priority: got o=%b c=%0d d=%h, expected 0/0 and first word held", a_ovf, a_cnt, a_data);
    end
    a_ready = 1'b1;
    idle(2);
    expect_drained("overflow");
  endtask

  task automatic test_ratio4();
    b_ready = 1'b1;
    cycle_b(8'h11, 1, 1, 0, '0);
    cycle_b(8'h22, 1, 0, 0, '0);
    cycle_b(8'h33, 1, 0, 0, '0);
    cycle_b(8'h44, 1, 0, 1, 32'h11223344);
    idle(4);
    expect_drained("ratio4");
    // Saturation of the 2-bit counter: five words, four dropped.
    b_ready = 1'b0;
    for (int w = 0; w < 5; w++) begin
      for (int i = 0; i < 4; i++) begin
        cycle_b(8'((16 * w) + i), 1, 0, (w == 0 && i == 3), 32'h00010203);
      end
    end
    idle(2);
    n_cmp++;
    if (b_ovf !== 1'b1 || b_cnt !== 2'd3 || b_data !== 32'h00010203) begin
      n_err++;
      $display("FAIL ratio4_saturate: got o=%b c=%0d d=%h, expected o=1 c=3 d=00010203", b_ovf, b_cnt, b_data);
    end
    b_ready = 1'b1;
    b_clr = 1'b1;
    idle(1);
    b_clr = 1'b0;
    n_cmp++;
    if (b_valid !== 1'b0 || b_ovf !== 1'b0 || b_cnt !== 2'd0) begin
      n_err++;
      $display("FAIL ratio4_clear: got v=%b o=%b c=%0d, expected 0/0/0", b_valid, b_ovf, b_cnt);
    end
    expect_drained("ratio4_sat");
  endtask

  task automatic test_reset_mid();
    a_ready = 1'b0;
    cycle_a(16'h0031, 16'h1031, 1, 0, 0, '0);
    cycle_a(16'h0032, 16'h1032, 1, 0, 1, 64'h10321031_00320031);
    cycle_a(16'h0033, 16'h1033, 1, 0, 0, '0);
    idle(1);
    n_cmp++;
    if (a_valid !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_pre: got v=%b, expected 1", a_valid);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (a_valid !== 1'b0 || a_data !== 64'h0) begin
      n_err++;
      $display("FAIL reset_mid_async: got v=%b d=%h, expected v=0 d=0", a_valid, a_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    a_prev_valid = 1'b0; b_prev_valid = 1'b0;
    a_ready = 1'b1;
    cycle_a(16'h0034, 16'h1034, 1, 0, 0, '0);
    cycle_a(16'h0035, 16'h1035, 1, 0, 1, 64'h10351034_00350034);
    idle(3);
    expect_drained("reset_mid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_gaps();
    test_sync_mid();
    test_overflow();
    test_ratio4();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rx_demux_deser.md
Name: rx_demux_deser

Overview:
- Parametrised successor to the single-channel 16-to-32 receive demultiplexer.
- Captures NCH channels of IN_W-bit samples from the receiver module on one clock and packs RATIO consecutive samples per channel into one OUT_W = IN_W*RATIO word.
- Presents packed words on a valid/ready interface as a single-clock enable strobe, with no derived output clock.
- Adds sample-phase alignment, input qualification and overflow accounting; sits between the receiver-module CMOS inputs and the downstream DSP/packetiser.

Parameters:
- IN_W, 16, sample width per channel.
- RATIO, 2, samples packed per output word (>=2).
- NCH, 2, channel count; all channels share one clock and one enable.
- FIRST_LOW, 1, 1 = earliest sample in bits [IN_W-1:0]; 0 = earliest sample in the MSBs.
- CNT_W, 16, overflow counter width.

Ports:
- Clk  in  1  sample clock (122.88 MHz DCO).
- Reset_n  in  1  asynchronous active-low reset.
- In_dat  in  NCH*IN_W  channel c in bits [c*IN_W +: IN_W].
- In_en  in  1  qualifies In_dat on this edge.
- In_sync  in  1  with In_en: this sample is phase 0.
- Out_data  out  NCH*RATIO*IN_W  channel c in bits [c*OUT_W +: OUT_W].
- Out_valid  out  1  Out_data holds an unconsumed word.
- Out_ready  in  1  downstream accepts the word.
- Overflow  out  1  sticky: a completed word was dropped.
- Ovf_count  out  CNT_W  dropped-word count, saturating.
- Ovf_clr  in  1  synchronous clear of Overflow and Ovf_count.

Behaviour:
- Reset values (async assert, sync release):
  - Out_valid=0, Out_data=0, Overflow=0, Ovf_count=0.
  - Phase counter=0, capture-valid=0, slot registers=0.
- Stage 0, capture:
  - Every edge, In_dat, In_en and In_sync are registered into cap_dat, cap_en and cap_sync.
  - No combinational path from In_* to the packing logic.
- Stage 1, pack, on an edge where cap_en=1:
  - Effective phase p = 0 if cap_sync=1, else the phase counter. A sync mid-group discards the partial group silently, with no overflow.
  - If p<RATIO-1: slot[p] <= cap_dat; phase <= p+1.
  - If p==RATIO-1: the word is complete. Word = slot[0..RATIO-2] plus cap_dat, ordered per FIRST_LOW. Phase <= 0.
  - cap_en=0: phase and slots hold; gaps in In_en do not break a group.
- Output register, on a completed word:
  - If Out_valid=0, or Out_valid=1 and Out_ready=1: load Out_data; Out_valid=1.
  - If Out_valid=1 and Out_ready=0: new word dropped; Out_data holds the old word.
    - Overflow <= 1.
    - Ovf_count <= Ovf_count+1, saturating at all-ones.
- No word completing and Out_valid=1 and Out_ready=1: Out_valid <= 0.
- Out_ready is ignored while Out_valid=0.
- Out_data changes only on a load.
- Latency: last sample of a group on In_dat at edge k -> Out_valid=1 and Out_data updated after edge k+1.
- Throughput: one word per RATIO enabled samples; with Out_ready tied high, no drops at full rate.
- Ovf_clr, with priority over increment:
  - Overflow=0, Ovf_count=0 on that edge.
  - A drop on the same edge is lost from the count.
- In_sync without In_en is ignored.
- Reset mid-group discards the partial group; the first enabled sample after reset is phase 0.
- Channels are packed in lockstep; one phase counter serves all channels.

Decomposition:
- Shared package (rx_pkg): RX_IN_W=16, RX_RATIO=2, RX_NCH=2 defaults and a function computing the phase counter width clog2(RATIO).
- One natural sub-module: rx_lane_pack, per-channel slot registers and word assembly, instantiated NCH times by generate. The top owns capture, phase counter, handshake and overflow logic.

Test Plan:
- Defaults, Out_ready=1, In_en=1, In_sync on first sample. Ch0 0x0001,0x0002,0x0003,0x0004; ch1 0x1001..0x1004. Expected: Out_data ch0=0x00020001 then 0x00040003, ch1=0x10021001 then 0x10041003. Out_valid pulses every 2nd cycle, one cycle after each pair completes.
- FIRST_LOW=0, RATIO=4, IN_W=8, NCH=1. Samples 0x11,0x22,0x33,0x44 -> Out_data=0x11223344, exactly one Out_valid.
- In_en toggling 1,0,0,1 with 0xAAAA then 0xBBBB. Expected: one word 0xBBBBAAAA; no valid during gaps.
- Sync mid-group: sample 0x0005 (phase 0), then 0x0006 with In_sync, then 0x0007. Expected: word 0x00070006; Overflow stays 0.
- Out_ready=0 over 3 completed words. Expected: Out_data keeps the first word, Overflow=1, Ovf_count=2. Then Out_ready=1 -> Out_valid drops. Ovf_clr -> count 0.
- Reset_n low for one cycle mid-group with Out_valid=1. Expected: Out_valid=0 immediately (async). The next two samples after release form the next word.
